// File: rtl/utm_pkg.sv
// Shared widths, default encodings and sequencer FSM states for the UTM slice.
package utm_pkg;

    localparam int unsigned SYM_W   = 3;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] DEF_HALT_STATE  = 3'd7;
    localparam logic [STATE_W-1:0] DEF_START_STATE = 3'd0;

    typedef enum logic [2:0] {
        FSM_IDLE = 3'd0,
        FSM_READ = 3'd1,
        FSM_EXEC = 3'd2,
        FSM_WAIT = 3'd3,
        FSM_DONE = 3'd4
    } fsm_t;

endpackage

// File: rtl/utm_tape.sv
// Tape register file: one write port, a combinational head read port and a
// registered readback port (a same-cycle write returns the old value).
module utm_tape
    import utm_pkg::*;
#(
    parameter int unsigned TAPE_LEN = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_we,
    input  logic [$clog2(TAPE_LEN)-1:0] i_waddr,
    input  logic [SYM_W-1:0]            i_wdata,
    input  logic [$clog2(TAPE_LEN)-1:0] i_head,
    output logic [SYM_W-1:0]            o_head_sym,
    input  logic [$clog2(TAPE_LEN)-1:0] i_rd_addr,
    output logic [SYM_W-1:0]            o_rd_sym
);

    logic [SYM_W-1:0] r_cells [TAPE_LEN];
    logic [SYM_W-1:0] r_rd_sym;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cells  <= '{default: '0};
            r_rd_sym <= '0;
        end else begin
            if (i_we) begin
                r_cells[i_waddr] <= i_wdata;
            end
            r_rd_sym <= r_cells[i_rd_addr];
        end
    end

    assign o_head_sym = r_cells[i_head];
    assign o_rd_sym   = r_rd_sym;

endmodule

// File: rtl/utm_sequencer.sv
// Turing-machine step sequencer: owns tape, head, state and step counter and
// drives an external combinational transition function one step at a time.
module utm_sequencer
    import utm_pkg::*;
#(
    parameter int unsigned        TAPE_LEN    = 16,
    parameter logic [STATE_W-1:0] HALT_STATE  = DEF_HALT_STATE,
    parameter logic [STATE_W-1:0] START_STATE = DEF_START_STATE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        step_mode,
    input  logic                        step_go,
    input  logic [$clog2(TAPE_LEN)-1:0] init_head,
    input  logic [15:0]                 max_steps,
    input  logic                        ld_en,
    input  logic [$clog2(TAPE_LEN)-1:0] ld_addr,
    input  logic [SYM_W-1:0]            ld_sym,
    output logic [SYM_W-1:0]            rd_sym,
    output logic [STATE_W-1:0]          tm_state,
    output logic [SYM_W-1:0]            tm_sym,
    input  logic [STATE_W-1:0]          tm_next_state,
    input  logic [SYM_W-1:0]            tm_new_sym,
    input  logic                        tm_move_right,
    output logic                        busy,
    output logic                        done,
    output logic                        halt_ok,
    output logic                        fault,
    output logic                        timeout,
    output logic [$clog2(TAPE_LEN)-1:0] head,
    output logic [15:0]                 steps
);

    localparam int unsigned AW = $clog2(TAPE_LEN);

    fsm_t               r_fsm;
    logic [AW-1:0]      r_head;
    logic [STATE_W-1:0] r_state;
    logic [SYM_W-1:0]   r_sym;
    logic [15:0]        r_steps;
    logic               r_halt_ok;
    logic               r_fault;
    logic               r_timeout;

    logic               w_idle_done;
    logic               w_load_we;
    logic               w_exec_we;
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic [SYM_W-1:0]   w_wdata;
    logic [SYM_W-1:0]   w_head_sym;
    logic               w_at_edge;
    logic [15:0]        w_steps_inc;
    logic               w_limit;

    assign w_idle_done = (r_fsm == FSM_IDLE) || (r_fsm == FSM_DONE);
    assign w_load_we   = ld_en && w_idle_done;
    // An abort landing on EXEC suppresses the commit so the tape is retained.
    assign w_exec_we   = (r_fsm == FSM_EXEC) && !abort;
    assign w_we        = w_load_we || w_exec_we;
    assign w_waddr     = w_exec_we ? r_head : ld_addr;
    assign w_wdata     = w_exec_we ? tm_new_sym : ld_sym;

    assign w_at_edge   = tm_move_right ? (r_head == '1) : (r_head == '0);
    assign w_steps_inc = r_steps + 16'd1;
    assign w_limit     = (max_steps != '0) && (w_steps_inc == max_steps);

    utm_tape #(
        .TAPE_LEN (TAPE_LEN)
    ) u_tape (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_head     (r_head),
        .o_head_sym (w_head_sym),
        .i_rd_addr  (ld_addr),
        .o_rd_sym   (rd_sym)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm     <= FSM_IDLE;
            r_head    <= '0;
            r_state   <= START_STATE;
            r_sym     <= '0;
            r_steps   <= '0;
            r_halt_ok <= 1'b0;
            r_fault   <= 1'b0;
            r_timeout <= 1'b0;
        end else if (abort) begin
            r_fsm     <= FSM_IDLE;
            r_halt_ok <= 1'b0;
            r_fault   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_fsm)
                FSM_IDLE, FSM_DONE: begin
                    if (start) begin
                        r_head    <= init_head;
                        r_state   <= START_STATE;
                        r_steps   <= '0;
                        r_halt_ok <= 1'b0;
                        r_fault   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_fsm     <= FSM_READ;
                    end
                end
                FSM_READ: begin
                    if (r_state == HALT_STATE) begin
                        r_halt_ok <= 1'b1;
                        r_fsm     <= FSM_DONE;
                    end else begin
                        r_sym <= w_head_sym;
                        r_fsm <= FSM_EXEC;
                    end
                end
                FSM_EXEC: begin
                    r_state <= tm_next_state;
                    r_steps <= w_steps_inc;
                    // Edge fault outranks the step limit; the head stays put.
                    if (w_at_edge) begin
                        r_fault <= 1'b1;
                        r_fsm   <= FSM_DONE;
                    end else begin
                        r_head <= tm_move_right ? r_head + 1'b1 : r_head - 1'b1;
                        if (w_limit) begin
                            r_timeout <= 1'b1;
                            r_fsm     <= FSM_DONE;
                        end else if (step_mode) begin
                            r_fsm <= FSM_WAIT;
                        end else begin
                            r_fsm <= FSM_READ;
                        end
                    end
                end
                FSM_WAIT: begin
                    if (step_go || !step_mode) begin
                        r_fsm <= FSM_READ;
                    end
                end
                default: r_fsm <= FSM_IDLE;
            endcase
        end
    end

    assign tm_state = r_state;
    assign tm_sym   = r_sym;
    assign busy     = (r_fsm == FSM_READ) || (r_fsm == FSM_EXEC) || (r_fsm == FSM_WAIT);
    assign done     = (r_fsm == FSM_DONE);
    assign halt_ok  = r_halt_ok;
    assign fault    = r_fault;
    assign timeout  = r_timeout;
    assign head     = r_head;
    assign steps    = r_steps;

endmodule
